// File: rtl/float_accum_sequencer.sv
// rtl/float_accum_sequencer.sv - sequential float stream reduction driving an external adder
// Feeds each adder result back as Op1; a stalled adder is flagged and the rest of the stream drained.
module float_accum_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InData,
  input  logic             InLast,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      OutData,
  output logic [CNT_W-1:0] OutCount,
  output logic             OutError,
  output logic [31:0]      AddOp1,
  output logic [31:0]      AddOp2,
  output logic             AddInValid,
  input  logic [31:0]      AddResult,
  input  logic             AddResultValid
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_NEXT  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_GUARD = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [2:0]        state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_inc;

  // Held low during reset so nothing is taken while the block is being cleared.
  assign InReady    = !Reset && (state_q == ST_IDLE || state_q == ST_NEXT || state_q == ST_DRAIN);
  assign OutValid   = (state_q == ST_DONE);
  assign OutData    = acc_q;
  assign OutCount   = count_q;
  assign OutError   = err_q;
  assign AddOp1     = op1_q;
  assign AddOp2     = op2_q;
  assign AddInValid = (state_q == ST_ISSUE);

  assign in_xfer   = InValid && InReady;
  assign out_xfer  = OutValid && OutReady;
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    wait_d  = wait_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          acc_d   = InData;
          count_d = CNT_W'(1);
          err_d   = 1'b0;
          state_d = InLast ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (in_xfer) begin
          op1_d   = acc_q;
          op2_d   = InData;
          last_d  = InLast;
          count_d = count_inc;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = '0;
        state_d = ST_GUARD;
      end
      // The adder still shows the previous result's valid here; it is not ours yet.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (AddResultValid) begin
          acc_d   = AddResult;
          state_d = last_q ? ST_DONE : ST_NEXT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = last_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_xfer) begin
          count_d = count_inc;
          if (InLast) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      wait_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

endmodule

// File: tb/tb_float_accum_sequencer.sv
// tb/tb_float_accum_sequencer.sv - scoreboard bench for float_accum_sequencer
// Adder model uses a table of hand-computed sums for the operand pairs the vectors produce.
module tb_float_accum_sequencer;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [31:0]   InData = '0;
  logic          InLast = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [31:0]   OutData;
  logic [CW-1:0] OutCount;
  logic          OutError;
  logic [31:0]   AddOp1, AddOp2;
  logic          AddInValid;
  logic [31:0]   AddResult = '0;
  logic          AddResultValid = 1'b0;

  float_accum_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData), .InLast(InLast),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutCount(OutCount), .OutError(OutError),
    .AddOp1(AddOp1), .AddOp2(AddOp2), .AddInValid(AddInValid),
    .AddResult(AddResult), .AddResultValid(AddResultValid)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]   d;
    logic [CW-1:0] c;
    logic          e;
  } out_t;

  out_t        exp_out[$];
  logic [63:0] exp_op[$];
  out_t        mon_e;
  logic [63:0] mon_op;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge Clock) begin
    if (!Reset && OutValid && OutReady) begin
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out actual=%0h required=none", OutData);
      end else begin
        mon_e = exp_out.pop_front();
        chk("out_data", 64'(OutData), 64'(mon_e.d));
        chk("out_count", 64'(OutCount), 64'(mon_e.c));
        chk("out_error", 64'(OutError), 64'(mon_e.e));
      end
    end
    if (!Reset && AddInValid) begin
      if (exp_op.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_add actual=%0h_%0h required=none", AddOp1, AddOp2);
      end else begin
        mon_op = exp_op.pop_front();
        chk("add_ops", {AddOp1, AddOp2}, mon_op);
      end
    end
  end

  // Adder model
  int          lat_cfg = 5;
  bit          hold_stale = 0;
  bit          no_resp = 0;
  int          lat_cnt = 0;
  logic        pending = 1'b0;
  logic        clr_pending = 1'b0;
  logic [31:0] res_pending = '0;

  function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'h3F000000}: return 32'h40600000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40800000, 32'h3F000000}: return 32'h40900000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (AddInValid) begin
      pending     <= !no_resp;
      lat_cnt     <= lat_cfg;
      res_pending <= add_lut(AddOp1, AddOp2);
      if (hold_stale) clr_pending <= 1'b1;
      else AddResultValid <= 1'b0;
    end else begin
      if (clr_pending) begin
        AddResultValid <= 1'b0;
        clr_pending    <= 1'b0;
      end
      if (pending) begin
        if (lat_cnt <= 1) begin
          AddResultValid <= 1'b1;
          AddResult      <= res_pending;
          pending        <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l, output int acc_cyc);
    bit ok;
    bit done;
    done = 0;
    InValid = 1'b1; InData = d; InLast = l;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge Clock);
      ok = InReady;
      @(posedge Clock);
      if (ok) done = 1;
    end
    #1;
    InValid = 1'b0; InLast = 1'b0;
    acc_cyc = cyc;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && exp_out.size() != 0; n++) @(negedge Clock);
    chk("drain_timeout", 64'(exp_out.size()), 64'd0);
    @(posedge Clock); #1;
  endtask

  task automatic push_out(input logic [31:0] d, input int c, input logic e);
    out_t o;
    o.d = d; o.c = CW'(c); o.e = e;
    exp_out.push_back(o);
  endtask

  int t0, t1, t2, t3;

  initial begin
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_in_ready", 64'(InReady), 64'd0);
    chk("rst_out", {31'd0, OutValid, OutData}, 64'd0);
    chk("rst_cnt_err", {47'd0, OutError, OutCount}, 64'd0);
    chk("rst_add", {AddOp1, AddOp2}, 64'd0);
    chk("rst_add_valid", 64'(AddInValid), 64'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // single element
    push_out(32'h3F800000, 1, 1'b0);
    send(32'h3F800000, 1'b1, t0);
    chk("single_latency", 64'(OutValid), 64'd1);
    wait_drain();

    // three elements, 5-cycle adder
    exp_op.push_back({32'h3F800000, 32'h40000000});
    exp_op.push_back({32'h40400000, 32'h3F000000});
    push_out(32'h40600000, 3, 1'b0);
    send(32'h3F800000, 1'b0, t0);
    send(32'h40000000, 1'b0, t1);
    send(32'h3F000000, 1'b1, t2);
    wait_drain();

    // stale valid held through GUARD
    hold_stale = 1;
    exp_op.push_back({32'h40000000, 32'h40000000});
    exp_op.push_back({32'h40800000, 32'h3F000000});
    push_out(32'h40900000, 3, 1'b0);
    send(32'h40000000, 1'b0, t0);
    send(32'h40000000, 1'b0, t1);
    send(32'h3F000000, 1'b1, t2);
    wait_drain();
    hold_stale = 0;

    // timeout and drain
    no_resp = 1;
    exp_op.push_back({32'h3F800000, 32'h40000000});
    push_out(32'h3F800000, 4, 1'b1);
    send(32'h3F800000, 1'b0, t0);
    send(32'h40000000, 1'b0, t1);
    send(32'h40400000, 1'b0, t2);
    send(32'h3F000000, 1'b1, t3);
    chk("timeout_gap", 64'(t2 - t1), 64'(TO + 3));
    wait_drain();
    no_resp = 0;

    // backpressure
    OutReady = 1'b0;
    push_out(32'h40400000, 1, 1'b0);
    send(32'h40400000, 1'b1, t0);
    InValid = 1'b1; InData = 32'h3F800000; InLast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("bp_in_ready", 64'(InReady), 64'd0);
      chk("bp_hold", {OutValid, OutError, OutCount, OutData[29:0]},
          {1'b1, 1'b0, 16'd1, 30'h00400000});
    end
    @(posedge Clock); #1;
    OutReady = 1'b1;
    push_out(32'h3F800000, 1, 1'b0);
    send(32'h3F800000, 1'b1, t0);
    wait_drain();

    // reset while waiting on the adder
    lat_cfg = 20;
    exp_op.push_back({32'h3F800000, 32'h40000000});
    send(32'h3F800000, 1'b0, t0);
    send(32'h40000000, 1'b0, t1);
    repeat (5) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("mid_rst_out", {31'd0, OutValid, OutData}, 64'd0);
    chk("mid_rst_cnt_err", {46'd0, InReady, OutError, OutCount}, 64'd0);
    chk("mid_rst_add", {AddOp1, AddOp2}, 64'd0);
    chk("mid_rst_add_valid", 64'(AddInValid), 64'd0);
    Reset = 1'b0;
    push_out(32'h40000000, 1, 1'b0);
    send(32'h40000000, 1'b1, t0);
    wait_drain();
    repeat (30) @(posedge Clock);
    #1;
    chk("ops_consumed", 64'(exp_op.size()), 64'd0);
    chk("outs_consumed", 64'(exp_out.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
